// File: rtl/cache_line_mem_responder_if.sv
// Line-request bus between the cache controller (master) and its backing memory (slave).
interface cache_line_mem_responder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic              wvalid;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              busy;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic              wr_done;

    modport master (
        output req, req_we, req_addr, wvalid, wdata,
        input  ack, busy, rvalid, rdata, rlast, wr_done
    );

    modport slave (
        input  req, req_we, req_addr, wvalid, wdata,
        output ack, busy, rvalid, rdata, rlast, wr_done
    );
endinterface

// File: rtl/cache_line_mem_responder.sv
// Backing-memory model behind the cache: whole-line fills after a fixed latency
// and whole-line write-backs under a valid strobe, with resettable storage.
module cache_line_mem_responder #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cache_line_mem_responder_if.slave bus
);
    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);
    localparam logic [OFF-1:0]    LAST_BEAT = OFF'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RBURST, WRITE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] base_q;
    logic [OFF-1:0]    beat_q;
    logic [LAT_W-1:0]  lat_q;
    logic [ADDR_W-1:0] beat_addr;

    logic              ack_q;
    logic              busy_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rlast_q;
    logic              wr_done_q;

    // base_q is line-aligned, so OR-ing in the beat never crosses the line
    always_comb begin
        beat_addr = base_q | ADDR_W'(beat_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem       <= '{default: '0};
            base_q    <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            ack_q     <= 1'b0;
            wr_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    busy_q   <= 1'b0;
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    rdata_q  <= '0;
                    beat_q   <= '0;
                    lat_q    <= '0;
                    if (bus.req) begin
                        base_q <= bus.req_addr & LINE_MASK;
                        ack_q  <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= bus.req_we ? WRITE : WAIT;
                    end
                end
                WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        state    <= RBURST;
                        rvalid_q <= 1'b1;
                        rdata_q  <= mem[beat_addr];
                        beat_q   <= beat_q + OFF'(1);
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                RBURST: begin
                    rdata_q <= mem[beat_addr];
                    beat_q  <= beat_q + OFF'(1);
                    // Leave for IDLE while the final beat is on the bus so a new
                    // request can be taken at the edge that ends it.
                    if (beat_q == LAST_BEAT) begin
                        rlast_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WRITE: begin
                    if (bus.wvalid) begin
                        mem[beat_addr] <= bus.wdata;
                        beat_q         <= beat_q + OFF'(1);
                        if (beat_q == LAST_BEAT) begin
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                            wr_done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rlast   = rlast_q;
    assign bus.wr_done = wr_done_q;
endmodule

// File: tb/tb_cache_line_mem_responder.sv
// Directed bench for cache_line_mem_responder (ADDR_W=6, DATA_W=8, LINE_WORDS=4, LATENCY=3).
module tb_cache_line_mem_responder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cache_line_mem_responder_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    cache_line_mem_responder #(
        .ADDR_W    (6),
        .DATA_W    (8),
        .LINE_WORDS(4),
        .LATENCY   (3)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full-timing line fill: accept edge, then cycles 1..8; optional req pulse in cycle `pulse`.
    task automatic read_line(input logic [5:0] addr, input logic [31:0] data, input int pulse);
        logic [7:0] er;
        bus.req      = 1'b1;
        bus.req_we   = 1'b0;
        bus.req_addr = addr;
        tick();
        for (int c = 1; c <= 8; c++) begin
            bus.req = (c == pulse);
            if (c >= 4 && c <= 7) er = data[8*(c-4) +: 8];
            else                  er = 8'h00;
            check($sformatf("rd%0h_c%0d_ack", addr, c),    bus.ack,    (c == 1));
            check($sformatf("rd%0h_c%0d_busy", addr, c),   bus.busy,   (c <= 7));
            check($sformatf("rd%0h_c%0d_rvalid", addr, c), bus.rvalid, (c >= 4 && c <= 7));
            check($sformatf("rd%0h_c%0d_rlast", addr, c),  bus.rlast,  (c == 7));
            check($sformatf("rd%0h_c%0d_rdata", addr, c),  bus.rdata,  er);
            tick();
        end
        bus.req = 1'b0;
    endtask

    // Line write-back; pat bit j = wvalid in cycle j+1, data consumed low byte first.
    task automatic write_line(input logic [5:0] addr, input logic [31:0] data,
                              input logic [7:0] pat, input int n);
        int   beats;
        logic done;
        beats = 0;
        done  = 1'b0;
        bus.req      = 1'b1;
        bus.req_we   = 1'b1;
        bus.req_addr = addr;
        tick();
        bus.req    = 1'b0;
        bus.req_we = 1'b0;
        check("wr_ack", bus.ack, 1'b1);
        check("wr_busy_c1", bus.busy, 1'b1);
        for (int j = 0; j < n && !done; j++) begin
            bus.wvalid = pat[j];
            bus.wdata  = pat[j] ? data[8*beats +: 8] : 8'h5A;
            if (pat[j]) beats++;
            tick();
            bus.wvalid = 1'b0;
            if (beats == 4) begin
                check("wr_done_pulse", bus.wr_done, 1'b1);
                check("wr_busy_low", bus.busy, 1'b0);
                done = 1'b1;
            end else begin
                check($sformatf("wr_busy_j%0d", j), bus.busy, 1'b1);
                check($sformatf("wr_done_early_j%0d", j), bus.wr_done, 1'b0);
            end
        end
        check("wr_complete", done, 1'b1);
        tick();
        check("wr_done_single", bus.wr_done, 1'b0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.req      = 1'b0;
        bus.req_we   = 1'b0;
        bus.req_addr = '0;
        bus.wvalid   = 1'b0;
        bus.wdata    = '0;

        // Reset state
        tick();
        tick();
        check("rst_ack", bus.ack, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_rlast", bus.rlast, 1'b0);
        check("rst_wr_done", bus.wr_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Fill from reset-cleared memory
        read_line(6'h04, 32'h0000_0000, 0);

        // Stray write beats while idle must not touch storage
        bus.wvalid = 1'b1;
        bus.wdata  = 8'hFF;
        tick();
        tick();
        tick();
        bus.wvalid = 1'b0;
        check("idle_wvalid_busy", bus.busy, 1'b0);

        // Consecutive write-back, then read-after-write via an unaligned address
        write_line(6'h06, 32'hD4C3_B2A1, 8'h0F, 4);
        read_line(6'h05, 32'hD4C3_B2A1, 0);
        read_line(6'h00, 32'h0000_0000, 0);

        // Write-back with gaps: beat, idle, idle, beat, beat, idle, beat
        write_line(6'h08, 32'h4433_2211, 8'h59, 7);
        read_line(6'h0B, 32'h4433_2211, 0);

        // req pulsed during the latency wait is ignored
        read_line(6'h04, 32'hD4C3_B2A1, 2);
        check("ignored_req_ack", bus.ack, 1'b0);
        check("ignored_req_busy", bus.busy, 1'b0);

        // Back-to-back fills with req held high: period LATENCY+LINE_WORDS
        bus.req      = 1'b1;
        bus.req_we   = 1'b0;
        bus.req_addr = 6'h04;
        tick();
        for (int k = 1; k <= 21; k++) begin
            int         p;
            logic [7:0] er;
            logic [31:0] d;
            d = 32'hD4C3_B2A1;
            p = (k - 1) % 7 + 1;
            if (k == 21) bus.req = 1'b0;
            if (p >= 4) er = d[8*(p-4) +: 8];
            else        er = 8'h00;
            check($sformatf("b2b_k%0d_ack", k),    bus.ack,    (p == 1));
            check($sformatf("b2b_k%0d_busy", k),   bus.busy,   1'b1);
            check($sformatf("b2b_k%0d_rvalid", k), bus.rvalid, (p >= 4));
            check($sformatf("b2b_k%0d_rlast", k),  bus.rlast,  (p == 7));
            check($sformatf("b2b_k%0d_rdata", k),  bus.rdata,  er);
            tick();
        end
        check("b2b_end_ack", bus.ack, 1'b0);
        check("b2b_end_busy", bus.busy, 1'b0);
        check("b2b_end_rvalid", bus.rvalid, 1'b0);
        tick();

        // Reset during the second read beat
        bus.req      = 1'b1;
        bus.req_we   = 1'b0;
        bus.req_addr = 6'h04;
        tick();
        bus.req = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("mid_rst_beat2_rvalid", bus.rvalid, 1'b1);
        check("mid_rst_beat2_rdata", bus.rdata, 8'hB2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", bus.rvalid, 1'b0);
        check("mid_rst_rlast", bus.rlast, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_rdata", bus.rdata, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        read_line(6'h05, 32'h0000_0000, 0);
        read_line(6'h0A, 32'h0000_0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
